// File: rtl/lfsr_arb_pkg.sv
// lfsr_arb_pkg: shared types and helper functions for the lfsr_arb block.
//   state_e    - arbiter FSM state encoding (IDLE, SERVE, RESEED).
//   lfsr_next  - one Galois right-shift step of the LFSR.
//   rr_pick    - round-robin search for the granted requester index.
// Both functions work on fixed maximum-width vectors; callers zero-extend
// their operands and truncate the result with a size cast.
package lfsr_arb_pkg;

  localparam int unsigned MAXW = 32;  // widest supported LFSR
  localparam int unsigned MAXN = 32;  // most supported requesters

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    RESEED
  } state_e;

  // Galois step, right shift: taps fold in when the bit shifted out is 1.
  // Zero-extended upper bits stay zero, so the result is exact for any
  // width up to MAXW.
  function automatic logic [MAXW-1:0] lfsr_next(input logic [MAXW-1:0] state,
                                                input logic [MAXW-1:0] taps);
    return (state >> 1) ^ (state[0] ? taps : '0);
  endfunction

  // First set request bit searching upward from ptr, wrapping modulo nreq.
  // Returns ptr when no request is set (callers only use it when req != 0).
  function automatic int unsigned rr_pick(input logic [MAXN-1:0] req,
                                          input int unsigned     ptr,
                                          input int unsigned     nreq);
    int unsigned idx;
    logic        found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < MAXN; i++) begin
      if (i < nreq && !found) begin
        idx = ptr + i;
        if (idx >= nreq) idx = idx - nreq;
        if (req[idx]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/lfsr_arb.sv
// lfsr_arb: shares one Galois LFSR between NREQ requesters with round-robin
// arbitration. Each grant hands the current LFSR word to one client and then
// steps the LFSR once, so consumption order is reproducible from the seed.
//
// Ports:
//   clk          clock
//   reset        asynchronous active-low reset
//   req          level request per client, held until granted
//   load         reseed strobe (wins over req)
//   load_seed    new seed; zero is replaced by SEED
//   gnt          one-hot grant, one-cycle pulse (registered)
//   rdata_valid  rdata valid, coincides with gnt
//   rdata        LFSR word for the granted client (state before the step)
//   rdata_id     index of the granted client
//   busy         high while the FSM is in RESEED
//
// Optional build macro LFSR_ARB_PERIOD_EN adds:
//   period_cnt   LFSR steps since reset/load; holds the period on wrap
//   period_done  one-cycle pulse when a step returns the state to the seed
module lfsr_arb
  import lfsr_arb_pkg::*;
#(
  parameter int unsigned      WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS  = 'h6,
  parameter int unsigned      NREQ  = 4,
  parameter logic [WIDTH-1:0] SEED  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic                    load,
  input  logic [WIDTH-1:0]        load_seed,
  output logic [NREQ-1:0]         gnt,
  output logic                    rdata_valid,
  output logic [WIDTH-1:0]        rdata,
  output logic [$clog2(NREQ)-1:0] rdata_id,
  output logic                    busy
`ifdef LFSR_ARB_PERIOD_EN
  ,
  output logic [WIDTH:0]          period_cnt,
  output logic                    period_done
`endif
);

  localparam int unsigned IDW = $clog2(NREQ);

  state_e           state_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [IDW-1:0]   rr_ptr;

  logic [IDW-1:0]   pick;
  logic [NREQ-1:0]  pick_onehot;
  logic [WIDTH-1:0] lfsr_step;
  logic [WIDTH-1:0] seed_eff;
  logic             do_grant;

  always_comb begin
    pick        = IDW'(rr_pick(MAXN'(req), 32'(rr_ptr), NREQ));
    pick_onehot = '0;
    pick_onehot[pick] = 1'b1;
    lfsr_step   = WIDTH'(lfsr_next(MAXW'(lfsr_q), MAXW'(TAPS)));
    seed_eff    = (load_seed == '0) ? SEED : load_seed;
    // load has priority, and the RESEED cycle ignores requests entirely
    do_grant    = !load && (state_q != RESEED) && (req != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      lfsr_q      <= SEED;
      rr_ptr      <= '0;
      gnt         <= '0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      rdata_id    <= '0;
      busy        <= 1'b0;
    end else begin
      gnt         <= '0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      rdata_id    <= '0;
      busy        <= 1'b0;
      if (load) begin
        state_q <= RESEED;
        lfsr_q  <= seed_eff;
        busy    <= 1'b1;
      end else if (state_q == RESEED) begin
        state_q <= IDLE;
      end else if (do_grant) begin
        state_q     <= SERVE;
        gnt         <= pick_onehot;
        rdata_valid <= 1'b1;
        rdata       <= lfsr_q;
        rdata_id    <= pick;
        lfsr_q      <= lfsr_step;
        rr_ptr      <= (pick == IDW'(NREQ - 1)) ? '0 : pick + 1'b1;
      end else begin
        state_q <= IDLE;
      end
    end
  end

`ifdef LFSR_ARB_PERIOD_EN
  logic [WIDTH-1:0] seed_q;
  logic             wrapped_q;  // last step hit the seed; next step restarts at 1

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seed_q      <= SEED;
      period_cnt  <= '0;
      period_done <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      period_done <= 1'b0;
      if (load) begin
        seed_q     <= seed_eff;
        period_cnt <= '0;
        wrapped_q  <= 1'b0;
      end else if (do_grant) begin
        period_cnt  <= wrapped_q ? (WIDTH+1)'(1) : period_cnt + 1'b1;
        period_done <= (lfsr_step == seed_q);
        wrapped_q   <= (lfsr_step == seed_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_arb.sv
module tb_lfsr_arb;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = '0;
  logic       load = 1'b0;
  logic [2:0] load_seed = '0;
  logic [3:0] gnt;
  logic       rdata_valid;
  logic [2:0] rdata;
  logic [1:0] rdata_id;
  logic       busy;
`ifdef LFSR_ARB_PERIOD_EN
  logic [3:0] period_cnt;
  logic       period_done;
`endif

  int total = 0;
  int bad   = 0;

  lfsr_arb #(.WIDTH(3), .TAPS(3'h6), .NREQ(4), .SEED(3'd1)) dut (
    .clk(clk), .reset(reset), .req(req), .load(load), .load_seed(load_seed),
    .gnt(gnt), .rdata_valid(rdata_valid), .rdata(rdata), .rdata_id(rdata_id),
    .busy(busy)
`ifdef LFSR_ARB_PERIOD_EN
    , .period_cnt(period_cnt), .period_done(period_done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pre_rst;
    logic [3:0] req;
    logic       load;
    logic [2:0] seed;
    logic [3:0] gnt;
    logic       vld;
    logic [2:0] rdata;
    logic [1:0] id;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic pr, input logic [3:0] r, input logic ld, input logic [2:0] sd,
                     input logic [3:0] g, input logic v, input logic [2:0] d,
                     input logic [1:0] id, input logic b);
    vec_t e;
    e.pre_rst = pr; e.req = r; e.load = ld; e.seed = sd;
    e.gnt = g; e.vld = v; e.rdata = d; e.id = id; e.busy = b;
    tbl.push_back(e);
  endtask

  // drive inputs at the falling edge, sample 1 time unit after the rising edge
  task automatic apply(input logic [3:0] r, input logic ld, input logic [2:0] sd);
    @(negedge clk);
    req = r; load = ld; load_seed = sd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; req = '0; load = 1'b0; load_seed = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_vld", 32'(rdata_valid), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_id", 32'(rdata_id), 0);
    chk("rst_busy", 32'(busy), 0);
`ifdef LFSR_ARB_PERIOD_EN
    chk("rst_pcnt", 32'(period_cnt), 0);
    chk("rst_pdone", 32'(period_done), 0);
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  // reference: LFSR step straight from the Galois rule
  function automatic int lstep(input int s);
    return (s >> 1) ^ ((s & 1) != 0 ? 6 : 0);
  endfunction

  initial begin
    // directed table
    add(1, 4'b0001, 0, 0, 4'b0001, 1, 1, 0, 0);
    add(0, 4'b0001, 0, 0, 4'b0001, 1, 6, 0, 0);
    add(0, 4'b0001, 0, 0, 4'b0001, 1, 3, 0, 0);
    add(0, 4'b0001, 0, 0, 4'b0001, 1, 7, 0, 0);
    add(0, 4'b0001, 0, 0, 4'b0001, 1, 5, 0, 0);
    add(0, 4'b0001, 0, 0, 4'b0001, 1, 4, 0, 0);
    add(0, 4'b0001, 0, 0, 4'b0001, 1, 2, 0, 0);
    add(0, 4'b0001, 0, 0, 4'b0001, 1, 1, 0, 0);
    add(1, 4'b1111, 0, 0, 4'b0001, 1, 1, 0, 0);
    add(0, 4'b1111, 0, 0, 4'b0010, 1, 6, 1, 0);
    add(0, 4'b1111, 0, 0, 4'b0100, 1, 3, 2, 0);
    add(0, 4'b1111, 0, 0, 4'b1000, 1, 7, 3, 0);
    add(0, 4'b1111, 0, 0, 4'b0001, 1, 5, 0, 0);
    add(0, 4'b1001, 0, 0, 4'b1000, 1, 4, 3, 0);
    add(0, 4'b1001, 0, 0, 4'b0001, 1, 2, 0, 0);
    add(0, 4'b0010, 1, 5, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b0010, 0, 0, 4'b0000, 0, 0, 0, 0);
    add(0, 4'b0010, 0, 0, 4'b0010, 1, 5, 1, 0);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 1);
    add(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0);
    add(0, 4'b0001, 0, 0, 4'b0001, 1, 1, 0, 0);

    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) do_reset();
      apply(tbl[i].req, tbl[i].load, tbl[i].seed);
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_vld", i), 32'(rdata_valid), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].rdata));
        chk($sformatf("tbl%0d_id", i), 32'(rdata_id), 32'(tbl[i].id));
      end
    end

    // asynchronous reset while a grant is showing
    do_reset();
    apply(4'b1111, 0, 0);
    chk("mid_gnt_before", 32'(gnt), 1);
    apply(4'b1111, 0, 0);
    chk("mid_gnt_before2", 32'(gnt), 2);
    #2 reset = 1'b0;
    #1;
    chk("mid_gnt", 32'(gnt), 0);
    chk("mid_vld", 32'(rdata_valid), 0);
    chk("mid_busy", 32'(busy), 0);
    @(negedge clk);
    reset = 1'b1; req = '0;
    apply(4'b0100, 0, 0);
    chk("mid_after_rdata", 32'(rdata), 1);
    chk("mid_after_id", 32'(rdata_id), 2);

`ifdef LFSR_ARB_PERIOD_EN
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      apply(4'b0001, 0, 0);
      chk($sformatf("per%0d_done", i), 32'(period_done), (i == 7) ? 1 : 0);
      chk($sformatf("per%0d_cnt", i), 32'(period_cnt), (i <= 7) ? i : i - 7);
    end
`endif

    // randomized run against a behavioural model
    begin
      int m_lfsr, m_ptr, m_n;
      bit m_reseed;
      do_reset();
      m_lfsr = 1; m_ptr = 0; m_reseed = 0; m_n = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        logic [3:0] r;
        logic       ld;
        logic [2:0] sd;
        int e_gnt, e_vld, e_d, e_id, e_busy, e_done;
        r  = 4'($urandom_range(0, 15));
        ld = ($urandom_range(0, 9) == 0);
        sd = 3'($urandom_range(0, 7));
        e_gnt = 0; e_vld = 0; e_d = 0; e_id = 0; e_busy = 0; e_done = 0;
        if (ld) begin
          m_lfsr = (sd == 0) ? 1 : int'(sd);
          m_reseed = 1; m_n = 0; e_busy = 1;
        end else if (m_reseed) begin
          m_reseed = 0;
        end else if (r != 0) begin
          int k;
          bit found;
          found = 0; k = 0;
          for (int i = 0; i < 4; i++) begin
            int c;
            c = (m_ptr + i) % 4;
            if (!found && r[c]) begin k = c; found = 1; end
          end
          e_gnt = 1 << k; e_vld = 1; e_d = m_lfsr; e_id = k;
          m_lfsr = lstep(m_lfsr);
          m_ptr = (k + 1) % 4;
          m_n++;
          e_done = (m_n % 7 == 0) ? 1 : 0;
        end
        apply(r, ld, sd);
        chk("rnd_gnt", 32'(gnt), e_gnt);
        chk("rnd_vld", 32'(rdata_valid), e_vld);
        chk("rnd_busy", 32'(busy), e_busy);
        if (e_vld != 0) begin
          chk("rnd_rdata", 32'(rdata), e_d);
          chk("rnd_id", 32'(rdata_id), e_id);
        end
`ifdef LFSR_ARB_PERIOD_EN
        chk("rnd_pdone", 32'(period_done), e_done);
        chk("rnd_pcnt", 32'(period_cnt), (m_n == 0) ? 0 : ((m_n - 1) % 7) + 1);
`endif
      end
    end

    @(negedge clk);
    req = '0; load = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lfsr_arb.md
Name: lfsr_arb

Overview:
Shares one LFSR pseudo-random source between NREQ requesters using round-robin arbitration. Each grant delivers exactly one LFSR word to one requester, then advances the LFSR by one step. Consumption order is therefore deterministic and reproducible from the seed. The block sits between the lfsr datapath and the test/stimulus clients that need random words.

Parameters:
- WIDTH, 3: LFSR state and word width in bits.
- TAPS, 'h6: Galois tap mask, WIDTH bits.
- NREQ, 4: number of requesters, at least 2.
- SEED, 1: reset seed and zero-seed substitute; must be nonzero.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per client; held until granted.
- load  in  1  reseed strobe.
- load_seed  in  WIDTH  new seed, sampled when load=1.
- gnt  out  NREQ  one-hot grant, one-cycle pulse.
- rdata_valid  out  1  rdata is valid this cycle; coincides with gnt.
- rdata  out  WIDTH  random word for the granted client.
- rdata_id  out  $clog2(NREQ)  index of the granted client.
- busy  out  1  high in the RESEED state.

Behaviour:
- Reset: state=SEED, rr_ptr=0, FSM=IDLE. gnt, rdata_valid, rdata, rdata_id and busy are all 0.
- LFSR step (Galois, right shift): next = (state >> 1) ^ (state[0] ? TAPS : 0).
- FSM states:
  - IDLE: no grant issued.
  - SERVE: a grant was issued this cycle.
  - RESEED: one cycle after a load.
- Transitions (evaluated each clock edge, in priority order):
  - load=1 → RESEED. State is set to load_seed, or to SEED if load_seed==0. No grant that cycle, even if req!=0.
  - In RESEED: busy=1, no grant, req ignored → IDLE next cycle.
  - Otherwise, req!=0 → SERVE.
  - Otherwise → IDLE.
- Grant selection: the first set req bit searching upward from rr_ptr, wrapping modulo NREQ.
  - On grant to index k: rr_ptr = (k+1) mod NREQ.
- Latency: req sampled at edge t; gnt, rdata_valid, rdata and rdata_id are registered outputs valid in cycle t+1.
  - rdata is the LFSR state before the step.
  - The LFSR steps once per grant and never otherwise.
- Throughput: at most one grant per cycle. With several requests held continuously, back-to-back grants rotate among the active clients.
- A requester must drop req in the cycle after its gnt pulse, or it is counted as a new request.
- load and req in the same cycle: load wins; the request stays pending.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous); the pending grant is lost.
- The all-zero LFSR state is unreachable: the reset seed and the zero-seed substitution both prevent it.

Optional Feature:
- Macro: LFSR_ARB_PERIOD_EN.
- When defined:
  - Adds output period_cnt [WIDTH+1 bits] and output period_done [1].
  - period_cnt counts LFSR steps since the last reset or load.
  - When a step returns the state to the seed value, period_done pulses for one cycle and period_cnt holds that count until the next step.
  - The count restarts from 1 on the following step.
- When undefined: these ports and their logic do not exist. Core behaviour is identical in both builds.

Decomposition:
- Package lfsr_arb_pkg:
  - state_e enum {IDLE, SERVE, RESEED}.
  - Function lfsr_next(state, taps).
  - Function rr_pick(req, ptr) returning the granted index.
- Sub-module: lfsr_arb holds the arbiter, FSM and LFSR register inline, with no separate LFSR instance. The step logic lives in the shared package function.

Test Plan:
- Reset then sequence: reset low 2 cycles, then req=4'b0001 held for 8 cycles (dropping after each gnt as required) → rdata = 1, 6, 3, 7, 5, 4, 2, 1 with rdata_id=0.
- Round-robin: req=4'b1111 held continuously → rdata_id = 0, 1, 2, 3, 0 and rdata = 1, 6, 3, 7, 5.
- Skip idle clients: rr_ptr=1 with req=4'b1001 → grant to 3, then 0; gnt = 4'b1000 then 4'b0001.
- Load priority: load=1 with load_seed=5 and req=4'b0010 in the same cycle → no gnt, busy=1 for one cycle; the next grant returns rdata=5 with rdata_id=1.
- Zero seed: load_seed=0 → the next rdata is 1 (SEED).
- Period (LFSR_ARB_PERIOD_EN defined): seed 1 with continuous grants → period_done pulses on the 7th step, with period_cnt=7.
